// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations after s3; drives per-source bypass selects and load-use stall (0-cycle, combinational).
// No backpressure downstream: the entry record shifts every cycle, stall only holds s1a..s3.
module hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int TAG_W      = 5,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     flush,
    input  logic [TAG_W-1:0]         issue_rd,
    input  logic                     issue_writes_rd,
    input  logic                     issue_is_load,
    input  logic [NUM_SRC*TAG_W-1:0] src_tag,
    input  logic [NUM_SRC-1:0]       src_used,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] bypass_sel,
    output logic [NUM_STAGES-1:0]    stage_valid,
    output logic [CNT_W-1:0]         stall_count
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] rd;
        logic             writes;
        logic             is_load;
    } entry_t;

    entry_t                          entry_q [NUM_STAGES];
    logic [NUM_SRC-1:0][SEL_W-1:0]   sel;
    logic [NUM_SRC-1:0]              load_hit;
    logic [NUM_STAGES-1:0]           valid_bits;
    logic                            hazard;

    // Oldest-to-youngest scan so the youngest match overwrites older ones.
    always_comb begin
        sel      = '0;
        load_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (issue_valid && src_used[i] &&
                    (src_tag[i*TAG_W +: TAG_W] != '0) &&
                    entry_q[k].valid && entry_q[k].writes &&
                    (entry_q[k].rd == src_tag[i*TAG_W +: TAG_W])) begin
                    sel[i]      = SEL_W'(k + 1);
                    load_hit[i] = entry_q[k].is_load && (k < LOAD_READY);
                end
            end
        end
    end

    always_comb begin
        valid_bits = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            valid_bits[k] = entry_q[k].valid;
        end
    end

    assign hazard      = issue_valid && !flush && (|load_hit);
    assign stall       = !reset && hazard;
    assign bypass_sel  = reset ? '0 : sel;
    assign stage_valid = reset ? '0 : valid_bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                entry_q[k] <= '0;
            end
            stall_count <= '0;
        end else begin
            if (issue_valid && !flush && !hazard) begin
                entry_q[0] <= '{valid: 1'b1, rd: issue_rd,
                                writes: issue_writes_rd, is_load: issue_is_load};
            end else begin
                entry_q[0] <= '0;
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                entry_q[k] <= entry_q[k-1];
            end
            if (hazard && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule
